// File: rtl/os256_resample_ctrl_if.sv
// Input stream, tap bus and output stream of the resample controller.
// master = controller side, slave = stream source / taps / sink side.
interface os256_resample_ctrl_if;
    logic signed [15:0] in_data;
    logic               in_valid;
    logic               in_ready;
    logic               tap_shift;
    logic        [7:0]  tap_phase;
    logic signed [15:0] tap_din;
    logic signed [31:0] kout0;
    logic signed [31:0] kout1;
    logic signed [31:0] kout2;
    logic signed [31:0] kout3;
    logic signed [15:0] out_data;
    logic               out_valid;

    modport master (
        input  in_data, in_valid,
        input  kout0, kout1, kout2, kout3,
        output in_ready, tap_shift, tap_phase, tap_din,
        output out_data, out_valid
    );

    modport slave (
        output in_data, in_valid,
        output kout0, kout1, kout2, kout3,
        input  in_ready, tap_shift, tap_phase, tap_din,
        input  out_data, out_valid
    );
endinterface

// File: rtl/os256_resample_ctrl.sv
// Lanczos-2 resample control: U8.8 phase accumulator driving the
// tap shift/phase bus, plus round/saturate of the summed tap products.
module os256_resample_ctrl #(
    parameter int FILL_COUNT  = 4,
    parameter int TAP_LATENCY = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [15:0] step,
    os256_resample_ctrl_if.master bus
);
    typedef enum logic {FETCH, ISSUE} state_t;

    state_t                   state, state_nx;
    logic [7:0]               frac, frac_nx;
    logic [8:0]               pending, pending_nx;
    logic [TAP_LATENCY-1:0]   dly;
    logic                     ready, xfer, issue;
    logic [15:0]              step_eff;
    logic [16:0]              acc;
    logic signed [33:0]       sum, rnd;
    logic signed [15:0]       sat, out_q;
    logic                     vld_q;

    assign step_eff = (step == 16'd0) ? 16'd1 : step;
    assign acc      = {9'd0, frac} + {1'b0, step_eff};

    // Reset gating keeps in_ready low for the whole reset window.
    assign ready = ~reset & enable & (state == FETCH) & (pending != 9'd0);
    assign xfer  = bus.in_valid & ready;

    always_comb begin
        state_nx   = state;
        frac_nx    = frac;
        pending_nx = pending;
        issue      = 1'b0;
        unique case (state)
            FETCH: begin
                if (enable) begin
                    if (xfer) pending_nx = pending - 9'd1;
                    if (pending_nx == 9'd0) state_nx = ISSUE;
                end
            end
            ISSUE: begin
                if (enable) begin
                    issue      = 1'b1;
                    frac_nx    = acc[7:0];
                    pending_nx = acc[16:8];
                    state_nx   = (acc[16:8] == 9'd0) ? ISSUE : FETCH;
                end
            end
        endcase
    end

    assign sum = {{2{bus.kout0[31]}}, bus.kout0}
               + {{2{bus.kout1[31]}}, bus.kout1}
               + {{2{bus.kout2[31]}}, bus.kout2}
               + {{2{bus.kout3[31]}}, bus.kout3};
    assign rnd = (sum + 34'sh8000) >>> 16;

    always_comb begin
        if (rnd > 34'sd32767)       sat = 16'sh7fff;
        else if (rnd < -34'sd32768) sat = 16'sh8000;
        else                        sat = rnd[15:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= FETCH;
            frac    <= 8'd0;
            pending <= FILL_COUNT[8:0];
            dly     <= '0;
            out_q   <= 16'sd0;
            vld_q   <= 1'b0;
        end else begin
            state   <= state_nx;
            frac    <= frac_nx;
            pending <= pending_nx;
            // Drains regardless of enable so in-flight issues complete.
            dly     <= (dly << 1) | TAP_LATENCY'(issue);
            vld_q   <= dly[TAP_LATENCY-1];
            if (dly[TAP_LATENCY-1]) out_q <= sat;
        end
    end

    assign bus.in_ready  = ready;
    assign bus.tap_shift = xfer;
    assign bus.tap_phase = frac;
    assign bus.tap_din   = bus.in_data;
    assign bus.out_data  = out_q;
    assign bus.out_valid = vld_q;
endmodule

// File: tb/tb_os256_resample_ctrl.sv
// Bench for os256_resample_ctrl: linear-interpolating tap model and
// an issue/position reference model derived from the U8.8 step rules.
module tb_os256_resample_ctrl;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b1;
    logic [15:0] step = 16'h0100;

    os256_resample_ctrl_if bus ();

    os256_resample_ctrl dut (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .step   (step),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Tap chain: tq[0]=t-1 (oldest) .. tq[3]=t2 (newest).
    logic signed [15:0] tq [4] = '{default: 16'sd0};
    logic        [7:0]  ph1 = 8'h00;
    logic signed [31:0] kn [4];
    logic signed [31:0] ka [4];
    logic signed [31:0] kb [4];
    logic signed [31:0] sk [4];
    logic               stub = 1'b0;

    always_comb begin
        kn[0] = 32'sd0;
        kn[1] = int'(tq[1]) * (256 - int'(ph1)) * 256;
        kn[2] = int'(tq[2]) * int'(ph1) * 256;
        kn[3] = 32'sd0;
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.tap_shift) begin
            tq[0] <= tq[1];
            tq[1] <= tq[2];
            tq[2] <= tq[3];
            tq[3] <= bus.tap_din;
        end
        ph1 <= bus.tap_phase;
        ka  <= kn;
        kb  <= ka;
    end

    assign bus.kout0 = stub ? sk[0] : kb[0];
    assign bus.kout1 = stub ? sk[1] : kb[1];
    assign bus.kout2 = stub ? sk[2] : kb[2];
    assign bus.kout3 = stub ? sk[3] : kb[3];

    int         oq_data [$];
    int         oq_cyc [$];
    int         ph_q [$];
    logic [7:0] last_ph = 8'h00;

    always @(negedge clk) begin
        if (bus.out_valid === 1'b1) begin
            oq_data.push_back(int'(bus.out_data));
            oq_cyc.push_back(cyc);
        end
        if (bus.tap_phase !== last_ph) ph_q.push_back(int'(bus.tap_phase));
        last_ph <= bus.tap_phase;
    end

    int xs [$];
    int xc [$];

    task automatic chk(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data = 16'sd77;
        tick(1);
        @(negedge clk);
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_tap_shift", bus.tap_shift, 0);
        chk("rst_tap_phase", bus.tap_phase, 0);
        chk("rst_out_data", bus.out_data, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        tick(1);
        reset = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("rel_in_ready", bus.in_ready, 1);
        tick(1);
    endtask

    task automatic make_xs(input int m, input bit rnd, input int cval);
        xs.delete();
        for (int i = 0; i < m; i++)
            xs.push_back(rnd ? int'($urandom_range(40000, 0)) - 20000 : cval);
    endtask

    task automatic feed(input int m, input int pv);
        int idx = 0;
        int guard = 0;
        xc.delete();
        while (idx < m && guard < 4000) begin
            bus.in_valid = ($urandom_range(99, 0) < pv);
            bus.in_data = 16'(xs[idx]);
            @(negedge clk);
            if (bus.in_valid && bus.in_ready) begin
                xc.push_back(cyc);
                idx++;
            end
            tick(1);
            guard++;
        end
        bus.in_valid = 1'b0;
        chk("feed_done", idx, m);
    endtask

    // Issue k sits at position k*step (U8.8) past the fill; it needs
    // 4+floor(pos) samples and interpolates between t0 and t1.
    task automatic check_model(input string tag, input int s, input int m,
                               input int ob);
        int se = (s == 0) ? 1 : s;
        int nout = oq_data.size() - ob;
        int k = 0;
        int n, p, e;
        while (k < 5000) begin
            n = 4 + (k * se) / 256;
            if (n > m) break;
            p = (k * se) % 256;
            e = (xs[n-3] * (256 - p) + xs[n-2] * p + 128) >>> 8;
            if (k < nout) chk(tag, oq_data[ob+k], e);
            k++;
        end
        chk({tag, "_count"}, nout, k);
    endtask

    task automatic check_latency(input string tag, input int ob,
                                 input int xi);
        if (oq_data.size() > ob) chk(tag, oq_cyc[ob] - xc[xi], 5);
        else chk({tag, "_none"}, oq_data.size(), ob + 1);
    endtask

    function automatic int exp_stub(input logic signed [31:0] a, b, c, d);
        longint s = longint'(a) + longint'(b) + longint'(c) + longint'(d);
        longint r = (s + 64'sd32768) >>> 16;
        if (r > 32767) r = 32767;
        if (r < -32768) r = -32768;
        return int'(r);
    endfunction

    task automatic stub_case(input string tag, input logic signed [31:0] a,
                             b, c, d, input int exp);
        int ob;
        stub = 1'b1;
        sk[0] = a; sk[1] = b; sk[2] = c; sk[3] = d;
        step = 16'h0100;
        do_reset();
        ob = oq_data.size();
        make_xs(4, 1'b0, 5);
        feed(4, 100);
        tick(10);
        chk({tag, "_count"}, oq_data.size() - ob, 1);
        if (oq_data.size() > ob) chk(tag, oq_data[ob], exp);
        chk({tag, "_model"}, exp_stub(a, b, c, d), exp);
        stub = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ob, pb, v, inr;
        logic signed [31:0] r0, r1, r2, r3;
        bus.in_valid = 1'b0;
        bus.in_data = 16'sd0;
        sk = '{default: 32'sd0};
        tick(1);

        step = 16'h0100;
        do_reset();
        ob = oq_data.size();
        make_xs(16, 1'b0, 1000);
        feed(16, 100);
        tick(20);
        check_latency("unity_latency", ob, 3);
        check_model("unity", 16'h0100, 16, ob);

        step = 16'h0080;
        do_reset();
        ob = oq_data.size();
        pb = ph_q.size();
        make_xs(10, 1'b0, 1000);
        feed(10, 100);
        tick(20);
        check_model("up2", 16'h0080, 10, ob);
        for (int i = ob; i < oq_data.size(); i++) begin
            v = oq_data[i];
            chk("up2_range", (v >= 999 && v <= 1001), 1);
        end
        chk("up2_phase_n", ph_q.size() - pb >= 6, 1);
        for (int j = 0; j < 6 && pb + j < ph_q.size(); j++)
            chk("up2_phase", ph_q[pb+j], ((j + 1) * 128) % 256);

        do_reset();
        ob = oq_data.size();
        make_xs(12, 1'b1, 0);
        feed(12, 60);
        tick(20);
        check_model("up2_rand", 16'h0080, 12, ob);

        step = 16'h0200;
        do_reset();
        ob = oq_data.size();
        make_xs(44, 1'b1, 0);
        feed(44, 70);
        tick(20);
        check_model("down2", 16'h0200, 44, ob);
        chk("down2_after_fill", oq_data.size() - ob - 1, 20);

        for (int i = 0; i < 3; i++) begin
            step = 16'($urandom_range(768, 1));
            do_reset();
            ob = oq_data.size();
            make_xs(24, 1'b1, 0);
            feed(24, 60);
            tick(20);
            check_model("rand_step", step, 24, ob);
        end

        step = 16'h0000;
        do_reset();
        ob = oq_data.size();
        pb = ph_q.size();
        make_xs(5, 1'b0, 1000);
        feed(5, 100);
        tick(300);
        chk("step0_gap", xc[4] - xc[3], 257);
        for (int j = 0; j < 256; j++)
            chk("step0_phase", ph_q[pb+j], (j + 1) % 256);
        check_model("step0", 16'h0000, 5, ob);

        stub_case("sat_pos", 32'sh7fff0000, 32'sh7fff0000,
                  32'sh7fff0000, 32'sh7fff0000, 32767);
        stub_case("sat_neg", 32'sh80000000, 32'sh80000000,
                  32'sh80000000, 32'sh80000000, -32768);
        stub_case("round_up", 32'sh00018000, 0, 0, 0, 2);
        for (int i = 0; i < 3; i++) begin
            r0 = $urandom; r1 = $urandom; r2 = $urandom; r3 = $urandom;
            if (i == 0) begin r0 = r0 >>> 4; r1 = r1 >>> 4; end
            stub_case("stub_rand", r0, r1, r2, r3, exp_stub(r0, r1, r2, r3));
        end

        step = 16'h0100;
        do_reset();
        ob = oq_data.size();
        pb = ph_q.size();
        make_xs(2, 1'b0, 1000);
        feed(2, 100);
        bus.in_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("stall_shift", bus.tap_shift, 0);
            inr = int'(bus.in_ready);
            chk("stall_ready", inr, 1);
            tick(1);
        end
        tick(6);
        chk("stall_no_out", oq_data.size() - ob, 0);
        chk("stall_no_issue", ph_q.size() - pb, 0);

        step = 16'h0000;
        do_reset();
        ob = oq_data.size();
        pb = ph_q.size();
        make_xs(4, 1'b0, 1000);
        feed(4, 100);
        tick(3);
        enable = 1'b0;
        tick(20);
        chk("en_drop_outs", oq_data.size() - ob, 3);
        chk("en_drop_issues", ph_q.size() - pb, 3);
        enable = 1'b1;
        tick(10);
        chk("en_resume_outs", oq_data.size() - ob, 9);

        do_reset();
        make_xs(4, 1'b0, 1000);
        feed(4, 100);
        tick(2);
        ob = oq_data.size();
        step = 16'h0100;
        do_reset();
        make_xs(4, 1'b0, 1000);
        feed(4, 100);
        tick(15);
        check_latency("rst_mid_latency", ob, 3);
        chk("rst_mid_count", oq_data.size() - ob, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/os256_resample_ctrl.md
Name: os256_resample_ctrl

Overview:
- Control and accumulate stage for the Lanczos-2 interpolator. It drives the shared shift/phase bus of the four os256_tap instances (t-1, t0, t1, t2) and accepts a 16-bit input sample stream with a valid/ready handshake.
- A U8.8 phase accumulator decides, per output sample, how many input samples to shift in and which 8-bit phase to present.
- It sums the four tap products, rounds and saturates them, and emits one 16-bit output sample per issue.

Parameters:
FILL_COUNT, 4, number of samples shifted in after reset before the first issue (primes the four taps).
TAP_LATENCY, 3, cycles from the issue cycle to valid kout on the taps; sets the depth of the issue delay line.

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high reset
enable  in  1  run enable; low freezes the FSM
step  in  16  resample ratio in_rate/out_rate, U8.8, sampled in each ISSUE cycle
in_data  in  16  input sample, signed
in_valid  in  1  in_data valid
in_ready  out  1  controller accepts in_data this cycle
tap_shift  out  1  shift strobe to all four taps
tap_phase  out  8  phase to all four taps (registered)
tap_din  out  16  sample into the first tap of the chain (= in_data)
kout0..kout3  in  32 each  tap products, S15.16
out_data  out  16  interpolated sample, signed
out_valid  out  1  one-cycle strobe; out_data is valid in this cycle

Behaviour:
- Reset values: in_ready=0, tap_shift=0, tap_phase=0, out_data=0, out_valid=0. Internal state on reset: frac=0, pending=FILL_COUNT, delay line cleared, state=FETCH.
- tap_shift = in_valid & in_ready. A transfer happens only when both are high in the same cycle.
- State FETCH:
  - in_ready = enable & (pending != 0).
  - On each transfer, pending decrements by 1.
  - When pending == 0 (either at entry or after the last transfer), next state is ISSUE.
  - in_valid low holds the state with no issue.
- State ISSUE (exactly one cycle; in_ready=0 and tap_shift=0 are mandatory):
  - tap_phase holds frac throughout this cycle.
  - step_eff = step, or 16'h0001 when step == 0.
  - acc = {9'b0, frac} + step_eff, computed in 17 bits.
  - At the clock edge: frac <= acc[7:0]; pending <= acc[16:8] (range 0..256).
  - Next state is ISSUE if acc[16:8] == 0 (back-to-back issues are allowed), otherwise FETCH.
- Tap timing contract:
  - For an issue in cycle T, no shift may occur in cycle T.
  - The taps multiply the data present in T+1 by the coefficient for the phase in T.
  - kout0..3 are valid in cycle T+TAP_LATENCY.
  - Shifts from T+1 onward are legal.
- A TAP_LATENCY-deep valid delay line marks which cycles carry kout to be accumulated.
- Accumulate (on the edge that ends cycle T+3):
  - sum = sign-extended 34-bit sum of kout0..3.
  - r = (sum + 34'h8000) >>> 16 (round half up).
  - Saturate r to [-32768, 32767] and register it to out_data.
  - out_valid=1 in cycle T+4, so total issue-to-output latency is 4.
  - out_data holds its value between strobes.
- enable low:
  - in_ready=0 and no ISSUE occurs; if in ISSUE, the state machine stays in ISSUE without updating frac or pending.
  - The delay line keeps draining, so in-flight issues still produce outputs.
- No output backpressure: downstream logic must accept every out_valid strobe.
- Reset asserted mid-operation:
  - In-flight delay-line entries are discarded, so no out_valid follows the reset.
  - The taps keep stale data, which is overwritten by the FILL_COUNT refill.

Test Plan:
- Constant input 1000, step=16'h0100, bench tap models: after 4 fill samples one output per input, each out_data=1000; first out_valid exactly 4 cycles after the first ISSUE.
- step=16'h0080 (2x up), constant 1000: tap_phase alternates 0x00/0x80, two outputs per input, each out_data in 999..1001.
- step=16'h0200 (2x down): 40 input transfers after fill give exactly 20 out_valid strobes. A step=0 case advances frac by 1 per issue with no shifts.
- Stubbed kout, checking round and saturate:
  - all kout=32'h7FFF0000 gives out_data=32767.
  - all kout=32'h80000000 gives out_data=-32768.
  - kout0=32'h00018000, others 0, gives out_data=2.
- Hold in_valid low for 10 cycles in FETCH: tap_shift=0 and no ISSUE during the stall. Separately, an enable drop while 3 issues are in flight still yields 3 outputs, and nothing more until enable returns.
- Assert reset with 2 issues in flight: no out_valid afterwards; in_ready returns the cycle after reset deasserts and 4 fill transfers precede the next ISSUE.
